// File: rtl/ofdm_symbol_scheduler_wifi.sv
`default_nettype none
// ============================================================================
// Module   : ofdm_symbol_scheduler_wifi
// Purpose  : Assembles WiFi OFDM symbols ahead of a 64-point IFFT.
//            Each bin 0..63 is filled in order with a null, a mapper data
//            sample, or a pilot word fetched from the pilot generator.
//            The frame length is a programmed number of symbols.
// Ports    : clk, reset (async, active-low)
//            start/abort/num_symbols  - frame control
//            data_valid/data_in/data_ready - mapper stream {I,Q}
//            pilot_req/pilot_valid/pilot_in - pilot generator handshake
//            valid_out/data_out/bin_idx/symbol_last - IFFT sample stream
//            frame_done/busy - frame status
// Revision : 1.0 - initial release
// ============================================================================
module ofdm_symbol_scheduler_wifi #(
    parameter int W     = 12,
    parameter int SYM_W = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [SYM_W-1:0] num_symbols,
    input  logic             data_valid,
    input  logic [2*W-1:0]   data_in,
    output logic             data_ready,
    output logic             pilot_req,
    input  logic             pilot_valid,
    input  logic [W-1:0]     pilot_in,
    output logic             valid_out,
    output logic [2*W-1:0]   data_out,
    output logic [5:0]       bin_idx,
    output logic             symbol_last,
    output logic             frame_done,
    output logic             busy
);

    localparam logic [1:0] c_ST_IDLE       = 2'd0;
    localparam logic [1:0] c_ST_BIN        = 2'd1;
    localparam logic [1:0] c_ST_WAIT_PILOT = 2'd2;
    localparam logic [1:0] c_ST_DONE       = 2'd3;

    localparam logic [SYM_W-1:0] c_SYM_ONE = SYM_W'(1);

    logic [1:0]       r_state,   w_state_nxt;
    logic [5:0]       r_bin_cnt, w_bin_nxt;
    logic [SYM_W-1:0] r_sym_cnt, w_sym_nxt;
    logic [SYM_W-1:0] r_num_sym, w_num_nxt;
    logic             r_busy,    w_busy_nxt;
    logic             r_valid,   w_valid_nxt;
    logic [2*W-1:0]   r_data,    w_data_nxt;
    logic [5:0]       r_idx,     w_idx_nxt;
    logic             r_last,    w_last_nxt;
    logic             r_done,    w_done_nxt;

    logic             w_is_null;
    logic             w_is_pilot;
    logic             w_emit;
    logic [2*W-1:0]   w_sample;
    logic [SYM_W-1:0] w_sym_inc;

    // Fixed 802.11a/g bin map in IFFT order: DC and the guard band are null,
    // four pilots, everything else carries data.
    assign w_is_null  = (r_bin_cnt == 6'd0) ||
                        ((r_bin_cnt >= 6'd27) && (r_bin_cnt <= 6'd37));
    assign w_is_pilot = (r_bin_cnt == 6'd7)  || (r_bin_cnt == 6'd21) ||
                        (r_bin_cnt == 6'd43) || (r_bin_cnt == 6'd57);
    assign w_sym_inc  = r_sym_cnt + c_SYM_ONE;

    always_comb begin
        w_state_nxt = r_state;
        w_bin_nxt   = r_bin_cnt;
        w_sym_nxt   = r_sym_cnt;
        w_num_nxt   = r_num_sym;
        w_busy_nxt  = r_busy;
        w_valid_nxt = 1'b0;
        w_data_nxt  = r_data;
        w_idx_nxt   = r_idx;
        w_last_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_emit      = 1'b0;
        w_sample    = '0;
        data_ready  = 1'b0;
        pilot_req   = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_num_nxt   = num_symbols;
                    w_busy_nxt  = 1'b1;
                    w_bin_nxt   = 6'd0;
                    w_sym_nxt   = '0;
                    w_state_nxt = (num_symbols == '0) ? c_ST_DONE : c_ST_BIN;
                end
            end
            c_ST_BIN: begin
                if (w_is_null) begin
                    w_emit = 1'b1;
                end else if (w_is_pilot) begin
                    // Request lasts exactly one cycle because the state
                    // moves on unconditionally.
                    pilot_req   = ~abort;
                    w_state_nxt = c_ST_WAIT_PILOT;
                end else begin
                    data_ready = ~abort;
                    if (data_valid && !abort) begin
                        w_emit   = 1'b1;
                        w_sample = data_in;
                    end
                end
            end
            c_ST_WAIT_PILOT: begin
                if (pilot_valid) begin
                    w_emit      = 1'b1;
                    w_sample    = {pilot_in, {W{1'b0}}};
                    w_state_nxt = c_ST_BIN;
                end
            end
            c_ST_DONE: begin
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase

        // Advance: emit the sample and step the bin; bin 63 closes a symbol
        // and either ends the frame or wraps straight into bin 0.
        if (w_emit) begin
            w_valid_nxt = 1'b1;
            w_data_nxt  = w_sample;
            w_idx_nxt   = r_bin_cnt;
            w_bin_nxt   = r_bin_cnt + 6'd1;
            if (r_bin_cnt == 6'd63) begin
                w_last_nxt = 1'b1;
                w_sym_nxt  = w_sym_inc;
                if (w_sym_inc == r_num_sym) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
        end

        // Abort overrides everything, including a start in IDLE.
        if (abort) begin
            w_state_nxt = c_ST_IDLE;
            w_busy_nxt  = 1'b0;
            w_valid_nxt = 1'b0;
            w_last_nxt  = 1'b0;
            w_done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= c_ST_IDLE;
            r_bin_cnt <= '0;
            r_sym_cnt <= '0;
            r_num_sym <= '0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_idx     <= '0;
            r_last    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bin_cnt <= w_bin_nxt;
            r_sym_cnt <= w_sym_nxt;
            r_num_sym <= w_num_nxt;
            r_busy    <= w_busy_nxt;
            r_valid   <= w_valid_nxt;
            r_data    <= w_data_nxt;
            r_idx     <= w_idx_nxt;
            r_last    <= w_last_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign valid_out   = r_valid;
    assign data_out    = r_data;
    assign bin_idx     = r_idx;
    assign symbol_last = r_last;
    assign frame_done  = r_done;
    assign busy        = r_busy;

endmodule
`default_nettype wire
